countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter CLK_HZ, 50000000: clk cycles per 1-second tick.
REQ-002 Parameter DEBOUNCE_CYC, 1000000: cycles a key level must be stable before it is accepted.
REQ-003 Parameter BLINK_CYC, 12500000: half-period of the DONE-state blink, in cycles.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 key_start_n  input  1  raw start/pause button, active-low, asynchronous to clk.
REQ-007 key_min_n  input  1  raw minute-set button, active-low, asynchronous to clk.
REQ-008 key_sec_n  input  1  raw second-set / clear button, active-low, asynchronous to clk.
REQ-009 min_h  output  3  minutes tens digit, BCD, range 0..5.
REQ-010 min_l  output  4  minutes units digit, BCD, range 0..9.
REQ-011 sec_h  output  3  seconds tens digit, BCD, range 0..5.
REQ-012 sec_l  output  4  seconds units digit, BCD, range 0..9.
REQ-013 display_flag  output  1  1 = digits visible, 0 = blanked; feeds the display stage.
REQ-014 alarm  output  1  high while in DONE.

Function
REQ-015 Each key passes a 2-FF synchroniser, then a debouncer.
- Debounced level changes only after DEBOUNCE_CYC consecutive equal samples.
- A press event is a 1-cycle pulse on the debounced 1->0 edge.
- Release generates no event.
REQ-016 States: SET, RUN, PAUSE, DONE.
REQ-017 SET behaviour:
- key_min event: minutes +1, 59 wraps to 00.
- key_sec event: seconds +1, 59 wraps to 00, no carry into minutes.
- key_start event: go to RUN if time != 00:00, otherwise stay in SET.
REQ-018 SET, simultaneous events in one cycle: key_min and key_sec both apply; key_start is evaluated on the pre-increment value.
REQ-019 Tick prescaler:
- Counts 0..CLK_HZ-1 only in RUN; emits a tick when it wraps.
- Holds its value in PAUSE.
- Clears to 0 in SET and DONE.
REQ-020 RUN, on each tick: decrement mm:ss by one second in BCD.
- Seconds x0 borrows from the seconds tens digit.
- :00 borrows from minutes; seconds become 59.
REQ-021 RUN, decrement that reaches 00:00: enter DONE on the same edge.
REQ-022 RUN, key_start event: go to PAUSE. If it coincides with a tick, pause wins and no decrement occurs. key_min and key_sec are ignored in RUN.
REQ-023 PAUSE behaviour:
- key_start event: back to RUN.
- key_sec event: time cleared to 00:00, go to SET.
- key_min ignored.
- key_start wins if it coincides with key_sec.
REQ-024 DONE behaviour:
- alarm = 1.
- display_flag toggles every BLINK_CYC cycles, starting at 1.
- Any key event: go to SET; time stays 00:00; alarm = 0; display_flag = 1.
REQ-025 In SET, RUN and PAUSE, display_flag = 1.
REQ-026 Digit outputs are registered and never leave their BCD ranges.

Reset
REQ-027 When rst_n = 0 at a clk edge, the following are forced:
- state = SET; digits 0 (00:00); display_flag = 1; alarm = 0.
- Prescaler and blink counter = 0.
- Synchroniser and debounced levels = 1 (released); no press events.
REQ-028 Reset mid-RUN or mid-DONE takes effect on that edge and has priority over all key events and ticks.

Structure
REQ-029 Shared package timer_pkg holds:
- the state enum (SET, RUN, PAUSE, DONE);
- BCD limit constants (tens max 5, units max 9).
REQ-030 Sub-module key_debounce (synchroniser + debouncer + press pulse) is instantiated three times; all other logic sits in countdown_timer.

Verification (CLK_HZ=10, DEBOUNCE_CYC=4, BLINK_CYC=3)
REQ-031 Reset, then hold key_min_n low 10 cycles and release -> exactly one minute increment: 01:00, state SET.
REQ-032 Bounce key_sec_n low/high every 2 cycles for 20 cycles -> no increment.
REQ-033 Set 00:02, press start -> 00:01 after 10 cycles; 00:00 after 20 cycles with alarm = 1; display_flag toggles every 3 cycles.
REQ-034 Set 01:00, press start, run 1 tick -> 00:59. Pause -> value holds 50 cycles. Press key_sec -> 00:00, state SET.
REQ-035 Start pressed at 00:00 in SET -> stays SET, no tick.
REQ-036 Assert rst_n = 0 for one cycle mid-RUN -> next cycle shows 00:00, SET, alarm = 0, display_flag = 1.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the mm:ss countdown timer.
package timer_pkg;

    localparam int unsigned TENS_W    = 3;
    localparam int unsigned UNITS_W   = 4;
    localparam int unsigned TENS_MAX  = 5;
    localparam int unsigned UNITS_MAX = 9;

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [TENS_W-1:0]  h;
        logic [UNITS_W-1:0] l;
    } bcd_pair_t;

    typedef struct packed {
        bcd_pair_t mm;
        bcd_pair_t ss;
    } bcd_time_t;

    // 00..59 increment, 59 wraps to 00
    function automatic bcd_pair_t bcd_inc(input bcd_pair_t p);
        bcd_pair_t r;
        r = p;
        if (p.l == UNITS_W'(UNITS_MAX)) begin
            r.l = '0;
            r.h = (p.h == TENS_W'(TENS_MAX)) ? '0 : p.h + TENS_W'(1);
        end else begin
            r.l = p.l + UNITS_W'(1);
        end
        return r;
    endfunction

    // 00..59 decrement, 00 wraps to 59
    function automatic bcd_pair_t bcd_dec(input bcd_pair_t p);
        bcd_pair_t r;
        r = p;
        if (p.l == '0) begin
            r.l = UNITS_W'(UNITS_MAX);
            r.h = (p.h == '0) ? TENS_W'(TENS_MAX) : p.h - TENS_W'(1);
        end else begin
            r.l = p.l - UNITS_W'(1);
        end
        return r;
    endfunction

    // One-second decrement; :00 borrows a minute
    function automatic bcd_time_t time_dec(input bcd_time_t t);
        bcd_time_t r;
        r    = t;
        r.ss = bcd_dec(t.ss);
        if (t.ss == '0) r.mm = bcd_dec(t.mm);
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key -> 2-FF synchroniser -> stability debouncer -> press pulse.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Level flips on the DEBOUNCE_CYC-th consecutive differing sample
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = level_q & ~level_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown timer: key-set time, 1 s tick run/pause, blinking alarm at 00:00.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned BLINK_CYC    = 12500000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_start_n,
    input  logic               key_min_n,
    input  logic               key_sec_n,
    output logic [TENS_W-1:0]  min_h,
    output logic [UNITS_W-1:0] min_l,
    output logic [TENS_W-1:0]  sec_h,
    output logic [UNITS_W-1:0] sec_l,
    output logic               display_flag,
    output logic               alarm
);

    localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned BLK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    state_e           state_q, state_d;
    bcd_time_t        time_q, time_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [BLK_W-1:0] blink_q, blink_d;
    logic             disp_q, disp_d;
    logic             alarm_q, alarm_d;
    logic             ev_start, ev_min, ev_sec;
    logic             tick_c;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_start (
        .clk(clk), .rst_n(rst_n), .key_n_i(key_start_n), .press_o(ev_start));
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_min (
        .clk(clk), .rst_n(rst_n), .key_n_i(key_min_n), .press_o(ev_min));
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_sec (
        .clk(clk), .rst_n(rst_n), .key_n_i(key_sec_n), .press_o(ev_sec));

    assign tick_c = (pre_q == PRE_W'(CLK_HZ - 1));

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        pre_d   = pre_q;
        blink_d = blink_q;
        disp_d  = disp_q;
        case (state_q)
            ST_SET: begin
                pre_d = '0;
                if (ev_min) time_d.mm = bcd_inc(time_q.mm);
                if (ev_sec) time_d.ss = bcd_inc(time_q.ss);
                // start qualifies on the pre-increment time
                if (ev_start && (time_q != '0)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ev_start) begin
                    state_d = ST_PAUSE;
                end else begin
                    pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
                    if (tick_c) begin
                        time_d = time_dec(time_q);
                        if (time_d == '0) state_d = ST_DONE;
                    end
                end
            end
            ST_PAUSE: begin
                if (ev_start) begin
                    state_d = ST_RUN;
                end else if (ev_sec) begin
                    time_d  = '0;
                    state_d = ST_SET;
                end
            end
            ST_DONE: begin
                pre_d = '0;
                if (ev_start || ev_min || ev_sec) begin
                    state_d = ST_SET;
                end else if (blink_q == BLK_W'(BLINK_CYC - 1)) begin
                    blink_d = '0;
                    disp_d  = ~disp_q;
                end else begin
                    blink_d = blink_q + BLK_W'(1);
                end
            end
            default: state_d = ST_SET;
        endcase
        // Outside DONE the display is steady and the blink phase is parked
        if (state_d != ST_DONE) begin
            disp_d  = 1'b1;
            blink_d = '0;
        end
        alarm_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_SET;
            time_q  <= '0;
            pre_q   <= '0;
            blink_q <= '0;
            disp_q  <= 1'b1;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            pre_q   <= pre_d;
            blink_q <= blink_d;
            disp_q  <= disp_d;
            alarm_q <= alarm_d;
        end
    end

    assign min_h        = time_q.mm.h;
    assign min_l        = time_q.mm.l;
    assign sec_h        = time_q.ss.h;
    assign sec_l        = time_q.ss.l;
    assign display_flag = disp_q;
    assign alarm        = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized bench for countdown_timer against a seconds-level behavioural model.
module tb_countdown_timer;

    localparam int unsigned CLK_HZ       = 10;
    localparam int unsigned DEBOUNCE_CYC = 4;
    localparam int unsigned BLINK_CYC    = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_start_n, key_min_n, key_sec_n;
    logic [2:0] min_h, sec_h;
    logic [3:0] min_l, sec_l;
    logic       display_flag, alarm;

    int total = 0;
    int bad   = 0;
    int m_mm, m_ss;

    countdown_timer #(
        .CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DEBOUNCE_CYC), .BLINK_CYC(BLINK_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .key_start_n(key_start_n), .key_min_n(key_min_n), .key_sec_n(key_sec_n),
        .min_h(min_h), .min_l(min_l), .sec_h(sec_h), .sec_l(sec_l),
        .display_flag(display_flag), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int cur();
        return int'(min_h) * 1000 + int'(min_l) * 100 + int'(sec_h) * 10 + int'(sec_l);
    endfunction

    function automatic int mval();
        return m_mm * 100 + m_ss;
    endfunction

    task automatic m_dec();
        if (m_ss == 0) begin
            m_ss = 59;
            m_mm = m_mm - 1;
        end else begin
            m_ss = m_ss - 1;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        key_start_n = 1'b1;
        key_min_n   = 1'b1;
        key_sec_n   = 1'b1;
        rst_n       = 1'b0;
        step(2);
        rst_n = 1'b1;
        m_mm  = 0;
        m_ss  = 0;
    endtask

    // mask: bit0 start, bit1 min, bit2 sec; keys pressed together
    task automatic press(input int mask, input int hold);
        if (mask[0]) key_start_n = 1'b0;
        if (mask[1]) key_min_n   = 1'b0;
        if (mask[2]) key_sec_n   = 1'b0;
        step(hold);
        key_start_n = 1'b1;
        key_min_n   = 1'b1;
        key_sec_n   = 1'b1;
        step(8);
    endtask

    // Waits for the displayed time to change; releases start after rel cycles
    task automatic wait_change(input int limit, input int rel, output int n);
        int prev;
        prev = cur();
        n    = 0;
        while (n < limit) begin
            step(1);
            n++;
            if (n == rel) key_start_n = 1'b1;
            if (cur() != prev) break;
        end
        key_start_n = 1'b1;
        if (cur() == prev) chk("wait_timeout", n, -1);
    endtask

    task automatic hold_check(input string tag, input int cycles);
        int moved;
        moved = 0;
        for (int i = 0; i < cycles; i++) begin
            step(1);
            if (cur() != mval()) moved++;
        end
        chk(tag, moved, 0);
    endtask

    initial begin
        int n, k, done;

        // Reset state
        do_reset();
        chk("rst_time", cur(), 0);
        chk("rst_disp", int'(display_flag), 1);
        chk("rst_alarm", int'(alarm), 0);

        // Long min hold -> exactly one increment
        key_min_n = 1'b0;
        step(10);
        key_min_n = 1'b1;
        step(10);
        m_mm = 1;
        chk("min_hold", cur(), mval());

        // Bouncing sec key never qualifies
        for (int i = 0; i < 5; i++) begin
            key_sec_n = 1'b0;
            step(2);
            key_sec_n = 1'b1;
            step(2);
        end
        step(10);
        chk("bounce", cur(), mval());

        // Start at 00:00 stays in SET
        do_reset();
        press(1, 8);
        hold_check("start_zero", 30);
        press(2, 7);
        m_mm = 1;
        chk("start_zero_set", cur(), mval());

        // Simultaneous keys at 00:00: both increments, start sees 00:00
        do_reset();
        press(7, 8);
        m_mm = 1;
        m_ss = 1;
        chk("simul_inc", cur(), mval());
        hold_check("simul_no_run", 30);

        // Wrap at 59, no carry from seconds into minutes
        do_reset();
        press(2, 6);
        m_mm = 1;
        for (int i = 0; i < 59; i++) press(4, 6);
        m_ss = 59;
        chk("sec_59", cur(), mval());
        press(4, 6);
        m_ss = 0;
        chk("sec_wrap", cur(), mval());
        for (int i = 0; i < 59; i++) press(2, 6);
        m_mm = 0;
        chk("min_wrap", cur(), mval());

        // 00:02 run to DONE, tick period, blink
        do_reset();
        press(4, 7);
        press(4, 7);
        m_ss = 2;
        chk("set_0002", cur(), mval());
        key_start_n = 1'b0;
        wait_change(40, 8, n);
        m_dec();
        chk("run_first", cur(), mval());
        chk("run_first_lat_ok", int'(n >= 10 && n <= 25), 1);
        wait_change(12, -1, n);
        m_dec();
        chk("run_period", n, 10);
        chk("run_zero", cur(), mval());
        chk("done_alarm", int'(alarm), 1);
        for (int i = 0; i < 12; i++) begin
            chk("blink", int'(display_flag), int'(((i / 3) % 2) == 0));
            step(1);
        end
        chk("done_alarm_hold", int'(alarm), 1);
        press(2, 8);
        chk("done_exit_time", cur(), 0);
        chk("done_exit_alarm", int'(alarm), 0);
        chk("done_exit_disp", int'(display_flag), 1);
        press(2, 8);
        m_mm = 1;
        chk("done_exit_set", cur(), mval());

        // 01:00 -> 00:59, pause holds, sec clears to SET
        do_reset();
        press(2, 8);
        m_mm = 1;
        key_start_n = 1'b0;
        wait_change(40, 8, n);
        m_dec();
        chk("borrow_0059", cur(), mval());
        press(1, 8);
        chk("pause_now", cur(), mval());
        hold_check("pause_hold", 50);
        chk("pause_disp", int'(display_flag), 1);
        press(4, 8);
        m_mm = 0;
        m_ss = 0;
        chk("pause_clear", cur(), mval());
        press(2, 8);
        m_mm = 1;
        chk("pause_clear_set", cur(), mval());

        // Reset mid-RUN
        do_reset();
        press(4, 8);
        press(4, 8);
        press(4, 8);
        m_ss = 3;
        key_start_n = 1'b0;
        wait_change(40, 8, n);
        m_dec();
        chk("pre_rst_run", cur(), mval());
        step(3);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        m_mm = 0;
        m_ss = 0;
        chk("midrun_rst_time", cur(), 0);
        chk("midrun_rst_alarm", int'(alarm), 0);
        chk("midrun_rst_disp", int'(display_flag), 1);
        hold_check("midrun_rst_idle", 25);

        // Randomized set/run/pause/resume/clear sequences
        for (int it = 0; it < 8; it++) begin
            do_reset();
            repeat ($urandom_range(0, 2)) begin
                press(2, $urandom_range(6, 10));
                m_mm = (m_mm + 1) % 60;
            end
            repeat ($urandom_range(1, 3)) begin
                press(4, $urandom_range(6, 10));
                m_ss = (m_ss + 1) % 60;
            end
            chk("rnd_set", cur(), mval());
            key_start_n = 1'b0;
            wait_change(40, 8, n);
            m_dec();
            chk("rnd_first", cur(), mval());
            done = int'(mval() == 0);
            k = $urandom_range(0, 2);
            while (done == 0 && k > 0) begin
                wait_change(12, -1, n);
                m_dec();
                chk("rnd_period", n, 10);
                chk("rnd_tick", cur(), mval());
                done = int'(mval() == 0);
                k--;
            end
            if (done != 0) begin
                chk("rnd_alarm", int'(alarm), 1);
                press(1 << $urandom_range(0, 2), 8);
                chk("rnd_done_exit", cur(), 0);
                chk("rnd_done_alarm", int'(alarm), 0);
            end else begin
                press(1, 8);
                hold_check("rnd_pause", $urandom_range(15, 40));
                press(2, 8);
                chk("rnd_pause_min_ignored", cur(), mval());
                if ($urandom_range(0, 1) == 1) begin
                    key_start_n = 1'b0;
                    wait_change(30, 8, n);
                    m_dec();
                    chk("rnd_resume", cur(), mval());
                    chk("rnd_resume_alarm", int'(alarm), int'(mval() == 0));
                end else begin
                    press(4, 8);
                    m_mm = 0;
                    m_ss = 0;
                    chk("rnd_clear", cur(), mval());
                    chk("rnd_clear_alarm", int'(alarm), 0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
